seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised multiplexed 7-segment display driver: holds a writable per-digit character buffer, decodes glyph codes to segment patterns, and time-multiplexes `NUM_DIGITS` digits onto one shared segment bus. It adds a programmable scan rate, inter-digit blanking (anti-ghosting) and per-digit blinking. It sits between the CPU/debug logic (write port) and the board's `SEG_OUT`/`SEG_SEL` pins.

## Interface
- `NUM_DIGITS`, default 8: digits scanned. Legal range 1..16.
- `SCAN_DIV`, default 1024: clock cycles per digit slot. Must be ≥2.
- `BLANK_CYCLES`, default 4: leading cycles of each slot with `SEG_SEL` forced to 0. Must be < `SCAN_DIV`.
- `BLINK_FRAMES`, default 64: full frames per blink phase. Must be ≥1.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `ENABLE` in 1: 0 forces both outputs to 0; counters keep running.
- `WR_EN` in 1: buffer write strobe, one entry per cycle.
- `WR_ADDR` in AW: digit index, where AW = max(1, clog2(`NUM_DIGITS`)). Digit 0 maps to `SEG_SEL[0]`.
- `WR_DATA` in 7: `[4:0]` glyph code, `[5]` dot, `[6]` blink attribute.
- `SEG_OUT` out 8: segments for the selected digit. Bit order from bit 7 to bit 0: upper, right-upper, right-lower, lower, left-lower, left-upper, center, dot. Active-high.
- `SEG_SEL` out `NUM_DIGITS`: one-hot digit select, active-high.

## Operation
- **Buffer:** `NUM_DIGITS` × 7-bit entries. On `RST`, every entry is set to glyph 0x10 (blank) with dot=1 and blink=0.
- **Writes:** when `WR_EN` is high and `WR_ADDR` < `NUM_DIGITS`, the entry is written at the clock edge. Out-of-range addresses are ignored and leave no side effect.
- **Glyph decode:**
  - Hex codes 0x0..0xF map to FC 60 DA F2 66 B6 BE E0 FE F6 EE 3E 9C 7A 9E 8E.
  - 0x10 = blank 00; 0x11 = H 6E; 0x12 = L 1C; 0x13 = '-' 02; 0x14 = o 3A; 0x15..0x1F = blank.
  - The dot attribute ORs bit 0 into the pattern.
- **Prescaler:** `pcnt` counts 0..`SCAN_DIV`−1 and wraps.
- **Digit index:** `idx` advances when `pcnt` = `SCAN_DIV`−1, wrapping from `NUM_DIGITS`−1 to 0.
- **Frames:** a frame ends when `idx` wraps. `fcnt` counts frames 0..`BLINK_FRAMES`−1. The blink phase toggles when `fcnt` wraps.
- **Output rule:** outputs are registered from the current `pcnt`, `idx`, buffer and phase.
  - `SEG_SEL` = onehot(`idx`) if `ENABLE` is high and `pcnt` ≥ `BLANK_CYCLES`; otherwise 0.
  - `SEG_OUT` = decode(buffer[`idx`]) under the same condition, otherwise 0.
  - If blink=1 and phase=1, `SEG_OUT` = 0x00 (dot also off) while `SEG_SEL` still asserts.
- **Reset values:** `SEG_OUT` = 0x00, `SEG_SEL` = 0, `pcnt` = 0, `idx` = 0, `fcnt` = 0, phase = 0 (visible).
- **Reset mid-operation:** `RST` high at any edge restores all reset values at that edge, including the buffer. It overrides a simultaneous write.

## Timing
- Each digit slot is `SCAN_DIV` cycles: `BLANK_CYCLES` cycles dark, then `SCAN_DIV`−`BLANK_CYCLES` cycles lit.
- A frame is `NUM_DIGITS`×`SCAN_DIV` cycles. A full blink period is 2×`BLINK_FRAMES` frames.
- **Output latency:** outputs lag counters by one cycle (registered). The first edge after `RST` falls outputs the slot-0, `pcnt`=0 state.
- **Write-to-display:**
  - The buffer updates at edge E.
  - If the written digit is being displayed, `SEG_OUT` changes at edge E+1, mid-slot, and `SEG_SEL` is unaffected.
  - Otherwise the new value appears the next time that digit is displayed.
- **Write at the slot boundary:** a write to the outgoing digit on the cycle `idx` advances does not affect the incoming digit.
- **`ENABLE` toggling:** takes effect on outputs one edge later. Scan and blink timing continue uninterrupted.

## Structure
- Shared package `seg7_pkg` holds:
  - glyph code constants (`GLYPH_BLANK` = 0x10, `GLYPH_H`, `GLYPH_L`, `GLYPH_DASH`, `GLYPH_O`);
  - segment bit-position constants;
  - the 7-bit entry field offsets (`DOT_BIT` = 5, `BLINK_BIT` = 6).
- Sub-module `seg7_glyph_decode`: purely combinational, 5-bit code plus dot in, 8-bit pattern out. It is instantiated once on the selected entry and is reusable by other display blocks.
- The top contains the buffer, `pcnt`/`idx`/`fcnt`/phase counters and the output registers.

## Test plan
Parameters for all scenarios: `NUM_DIGITS`=4, `SCAN_DIV`=4, `BLANK_CYCLES`=1, `BLINK_FRAMES`=2, `ENABLE`=1 unless stated.
- **Reset scan:** release `RST` with no writes -> `SEG_SEL` repeats the 16-cycle pattern 0000, 0001×3, 0000, 0010×3, 0000, 0100×3, 0000, 1000×3. `SEG_OUT` = 0x01 whenever `SEG_SEL`≠0, and 0x00 otherwise.
- **Decode:** write digit 0 = 0x11, digit 1 = 0x0A|dot, digit 2 = 0x0E, digit 3 = 0x1F -> lit `SEG_OUT` values are 0x6E, 0xEF, 0x9E, 0x00 respectively.
- **Blink:** write digit 2 = 0x08|blink -> digit 2 shows 0xFE for 2 frames (32 cycles) and 0x00 for the next 2 frames with `SEG_SEL`=0100 still asserted, repeating. Other digits are unaffected.
- **Mid-slot and out-of-range writes:**
  - Write digit 1 = 0x03 during its second lit cycle -> `SEG_OUT` becomes 0xF2 on the following edge.
  - `WR_ADDR`=5 is not representable with AW=2; instead, with `NUM_DIGITS`=3 and AW=2, `WR_ADDR`=3 -> no buffer change.
- **Enable:** drop `ENABLE` for 5 cycles mid-slot -> outputs 0 starting one edge later. On restore, the scan resumes at the position the counters would have reached anyway; phase and frame counts are undisturbed.
- **Reset mid-operation:** assert `RST` during slot 2 coincident with a write -> the next edge gives outputs 0, counters 0 and all entries blank+dot, and the write is discarded.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the 7-segment display blocks: glyph
//                codes, segment bit positions and buffer-entry field offsets.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Buffer entry layout: [4:0] glyph code, [5] dot, [6] blink attribute
  localparam int CODE_W    = 5;
  localparam int ENTRY_W   = 7;
  localparam int DOT_BIT   = 5;
  localparam int BLINK_BIT = 6;

  // Non-hex glyph codes
  localparam logic [CODE_W-1:0] GLYPH_BLANK = 5'h10;
  localparam logic [CODE_W-1:0] GLYPH_H     = 5'h11;
  localparam logic [CODE_W-1:0] GLYPH_L     = 5'h12;
  localparam logic [CODE_W-1:0] GLYPH_DASH  = 5'h13;
  localparam logic [CODE_W-1:0] GLYPH_O     = 5'h14;

  // Segment bit positions on the 8-bit segment bus (active-high)
  localparam int SEG_UPPER       = 7;
  localparam int SEG_RIGHT_UPPER = 6;
  localparam int SEG_RIGHT_LOWER = 5;
  localparam int SEG_LOWER       = 4;
  localparam int SEG_LEFT_LOWER  = 3;
  localparam int SEG_LEFT_UPPER  = 2;
  localparam int SEG_CENTER      = 1;
  localparam int SEG_DOT         = 0;

  // Entry value loaded on reset: blank glyph, dot lit, no blink
  localparam logic [ENTRY_W-1:0] ENTRY_RESET = {1'b0, 1'b1, GLYPH_BLANK};

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_glyph_decode
//  Description : Combinational glyph-code to segment-pattern decoder with a
//                dot overlay. Reusable by any 7-segment display block.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic              dot_i,
  output logic [7:0]        seg_o
);

  // Look up the glyph shape, then OR the dot segment in
  always_comb begin
    seg_o = 8'h00;
    case (code_i)
      5'h00:      seg_o = 8'hFC;
      5'h01:      seg_o = 8'h60;
      5'h02:      seg_o = 8'hDA;
      5'h03:      seg_o = 8'hF2;
      5'h04:      seg_o = 8'h66;
      5'h05:      seg_o = 8'hB6;
      5'h06:      seg_o = 8'hBE;
      5'h07:      seg_o = 8'hE0;
      5'h08:      seg_o = 8'hFE;
      5'h09:      seg_o = 8'hF6;
      5'h0A:      seg_o = 8'hEE;
      5'h0B:      seg_o = 8'h3E;
      5'h0C:      seg_o = 8'h9C;
      5'h0D:      seg_o = 8'h7A;
      5'h0E:      seg_o = 8'h9E;
      5'h0F:      seg_o = 8'h8E;
      GLYPH_H:    seg_o = 8'h6E;
      GLYPH_L:    seg_o = 8'h1C;
      GLYPH_DASH: seg_o = 8'h02;
      GLYPH_O:    seg_o = 8'h3A;
      default:    seg_o = 8'h00;  // blank and unused codes
    endcase
    seg_o[SEG_DOT] = seg_o[SEG_DOT] | dot_i;
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Multiplexed 7-segment driver: per-digit character buffer,
//                prescaled digit scan with leading blanking per slot and
//                per-digit blinking. Outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_FRAMES = 64,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [ENTRY_W-1:0]    wr_data_i,
  output logic [7:0]            seg_out_o,
  output logic [NUM_DIGITS-1:0] seg_sel_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PCNT_LIT = PW'(BLANK_CYCLES);
  localparam logic [AW-1:0] IDX_MAX  = AW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);
  localparam logic [AW:0]   DIGITS   = (AW + 1)'(NUM_DIGITS);

  logic [ENTRY_W-1:0]    buf_q [NUM_DIGITS];
  logic [PW-1:0]         pcnt_q,  pcnt_d;
  logic [AW-1:0]         idx_q,   idx_d;
  logic [FW-1:0]         fcnt_q,  fcnt_d;
  logic                  phase_q, phase_d;
  logic [7:0]            seg_out_q, seg_out_d;
  logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;

  logic                  slot_end;
  logic                  frame_end;
  logic                  lit;
  logic [ENTRY_W-1:0]    sel_entry;
  logic [7:0]            glyph_seg;

  assign sel_entry = buf_q[idx_q];

  seg7_glyph_decode u_decode (
    .code_i (sel_entry[CODE_W-1:0]),
    .dot_i  (sel_entry[DOT_BIT]),
    .seg_o  (glyph_seg)
  );

  // Scan timing: prescaler, digit index, frame counter and blink phase
  always_comb begin
    slot_end  = (pcnt_q == PCNT_MAX);
    frame_end = slot_end && (idx_q == IDX_MAX);
    pcnt_d    = slot_end ? '0 : pcnt_q + PW'(1);
    idx_d     = idx_q;
    fcnt_d    = fcnt_q;
    phase_d   = phase_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + AW'(1);
    end
    if (frame_end) begin
      if (fcnt_q == FCNT_MAX) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Next output values from the current counters, buffer entry and phase
  always_comb begin
    lit       = enable_i && (pcnt_q >= PCNT_LIT);
    seg_sel_d = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_out_d = 8'h00;
    // A blinking digit in its dark phase keeps its select but shows nothing
    if (lit && !(sel_entry[BLINK_BIT] && phase_q)) begin
      seg_out_d = glyph_seg;
    end
  end

  // Character buffer: reset to blank+dot, in-range writes only
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_q[i] <= ENTRY_RESET;
      end
    end else if (wr_en_i && ({1'b0, wr_addr_i} < DIGITS)) begin
      buf_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Counter and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q    <= '0;
      idx_q     <= '0;
      fcnt_q    <= '0;
      phase_q   <= 1'b0;
      seg_out_q <= 8'h00;
      seg_sel_q <= '0;
    end else begin
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      fcnt_q    <= fcnt_d;
      phase_q   <= phase_d;
      seg_out_q <= seg_out_d;
      seg_sel_q <= seg_sel_d;
    end
  end

  assign seg_out_o = seg_out_q;
  assign seg_sel_o = seg_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver with a cycle-count
//                based reference model (4-digit and 3-digit instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BL = 1;
  localparam int BF = 2;
  localparam int N3 = 3;

  logic       clk = 1'b0;
  logic       rst, enable, wr_en;
  logic [1:0] wr_addr;
  logic [6:0] wr_data;
  logic [7:0] seg_out;
  logic [3:0] seg_sel;

  logic       en3, wr3_en;
  logic [1:0] wr3_addr;
  logic [6:0] wr3_data;
  logic [7:0] seg_out3;
  logic [2:0] seg_sel3;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .seg_out_o(seg_out), .seg_sel_o(seg_sel)
  );

  seg7_scan_driver #(.NUM_DIGITS(N3), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)) dut3 (
    .clk_i(clk), .rst_i(rst), .enable_i(en3), .wr_en_i(wr3_en),
    .wr_addr_i(wr3_addr), .wr_data_i(wr3_data), .seg_out_o(seg_out3), .seg_sel_o(seg_sel3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Glyph table straight from the character set definition
  logic [7:0] tab [32] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E,
    8'h00, 8'h6E, 8'h1C, 8'h02, 8'h3A, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  // Model state: buffer contents and cycles elapsed since reset
  logic [6:0]  bm  [N];
  logic [6:0]  bm3 [N3];
  int unsigned cnt, cnt3;
  logic [3:0]  exp_sel;
  logic [7:0]  exp_out;
  logic [2:0]  exp_sel3;
  logic [7:0]  exp_out3;

  function automatic logic [15:0] ref_sel(input int unsigned c, input int n, input logic en);
    int pc = int'(c % SD);
    int id = int'((c / SD) % n);
    return (en && pc >= BL) ? (16'd1 << id) : 16'h0;
  endfunction

  function automatic logic [7:0] ref_out(input int unsigned c, input int n, input logic en,
                                         input logic [6:0] e);
    int unsigned frame = c / (SD * n);
    logic        dark  = ((frame / BF) % 2) == 1;
    if (ref_sel(c, n, en) == 16'h0) return 8'h00;
    if (e[6] && dark) return 8'h00;
    return tab[e[4:0]] | {7'b0, e[5]};
  endfunction

  // Advance one clock: form expectations from pre-edge state, then update model
  task automatic step();
    if (rst) begin
      exp_sel = '0; exp_out = '0; exp_sel3 = '0; exp_out3 = '0;
    end else begin
      exp_sel  = 4'(ref_sel(cnt, N, enable));
      exp_out  = ref_out(cnt, N, enable, bm[(cnt / SD) % N]);
      exp_sel3 = 3'(ref_sel(cnt3, N3, en3));
      exp_out3 = ref_out(cnt3, N3, en3, bm3[(cnt3 / SD) % N3]);
    end
    @(posedge clk);
    if (rst) begin
      cnt = 0; cnt3 = 0;
      for (int i = 0; i < N;  i++) bm[i]  = 7'h30;
      for (int i = 0; i < N3; i++) bm3[i] = 7'h30;
    end else begin
      if (wr_en) bm[wr_addr] = wr_data;
      if (wr3_en && wr3_addr < N3) bm3[wr3_addr] = wr3_data;
      cnt++; cnt3++;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] lsel;
    logic [7:0] lout;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (seg_sel !== 4'h0 || seg_out !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_hold sel=%b out=%h required sel=0000 out=00", seg_sel, seg_out);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      lsel = ((i % 4) == 0) ? 4'h0 : 4'(1 << ((i / 4) % 4));
      lout = (lsel == 4'h0) ? 8'h00 : 8'h01;
      n_cmp++;
      if (seg_sel !== lsel || seg_out !== lout || seg_sel !== exp_sel || seg_out !== exp_out) begin
        n_bad++;
        $display("FAIL reset_scan cyc=%0d sel=%b out=%h required sel=%b out=%h", i, seg_sel, seg_out, lsel, lout);
      end
    end
  endtask

  task automatic test_decode();
    logic [6:0] wv [4] = '{7'h11, 7'h2A, 7'h0E, 7'h1F};
    logic [7:0] lv [4] = '{8'h6E, 8'hEF, 8'h9E, 8'h00};
    for (int d = 0; d < 4; d++) begin
      wr_en = 1'b1; wr_addr = 2'(d); wr_data = wv[d];
      step();
      wr_en = 1'b0;
    end
    for (int i = 0; i < 32; i++) begin
      step();
      n_cmp++;
      if (seg_sel !== exp_sel || seg_out !== exp_out) begin
        n_bad++;
        $display("FAIL decode sel=%b out=%h required sel=%b out=%h", seg_sel, seg_out, exp_sel, exp_out);
      end
      for (int d = 0; d < 4; d++) begin
        if (exp_sel == 4'(1 << d)) begin
          n_cmp++;
          if (seg_out !== lv[d]) begin
            n_bad++;
            $display("FAIL decode_digit%0d out=%h required %h", d, seg_out, lv[d]);
          end
        end
      end
    end
  endtask

  task automatic test_blink();
    int lit_on = 0;
    int lit_off = 0;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 7'h48;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 160; i++) begin
      step();
      n_cmp++;
      if (seg_sel !== exp_sel || seg_out !== exp_out) begin
        n_bad++;
        $display("FAIL blink cnt=%0d sel=%b out=%h required sel=%b out=%h", cnt, seg_sel, seg_out, exp_sel, exp_out);
      end
      if (seg_sel == 4'b0100 && seg_out == 8'hFE) lit_on++;
      if (seg_sel == 4'b0100 && seg_out == 8'h00) lit_off++;
    end
    n_cmp++;
    if (lit_on == 0 || lit_off == 0) begin
      n_bad++;
      $display("FAIL blink_phases on=%0d off=%0d required both nonzero", lit_on, lit_off);
    end
  endtask

  task automatic test_midslot();
    int guard = 0;
    while ((cnt % 16) != 6 && guard < 32) begin
      step();
      guard++;
    end
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 7'h03;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (seg_sel !== exp_sel || seg_out !== exp_out) begin
      n_bad++;
      $display("FAIL midslot_write_edge sel=%b out=%h required sel=%b out=%h", seg_sel, seg_out, exp_sel, exp_out);
    end
    step();
    n_cmp++;
    if (seg_sel !== 4'b0010 || seg_out !== 8'hF2 || seg_out !== exp_out) begin
      n_bad++;
      $display("FAIL midslot_next_edge sel=%b out=%h required sel=0010 out=f2", seg_sel, seg_out);
    end
  endtask

  task automatic test_out_of_range();
    wr3_en = 1'b1; wr3_addr = 2'd3; wr3_data = 7'h08;
    step();
    wr3_en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      n_cmp++;
      if (seg_sel3 !== exp_sel3 || seg_out3 !== exp_out3 ||
          seg_out3 !== ((seg_sel3 == 3'b0) ? 8'h00 : 8'h01)) begin
        n_bad++;
        $display("FAIL oor_addr sel=%b out=%h required sel=%b out=%h", seg_sel3, seg_out3, exp_sel3, exp_out3);
      end
    end
    wr3_en = 1'b1; wr3_addr = 2'd2; wr3_data = 7'h05;
    step();
    wr3_en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      n_cmp++;
      if (seg_sel3 !== exp_sel3 || seg_out3 !== exp_out3) begin
        n_bad++;
        $display("FAIL inrange3 sel=%b out=%h required sel=%b out=%h", seg_sel3, seg_out3, exp_sel3, exp_out3);
      end
    end
  endtask

  task automatic test_enable();
    int guard = 0;
    while ((cnt % SD) != 2 && guard < 8) begin
      step();
      guard++;
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (seg_sel !== 4'h0 || seg_out !== 8'h00) begin
        n_bad++;
        $display("FAIL enable_off sel=%b out=%h required sel=0000 out=00", seg_sel, seg_out);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 70; i++) begin
      step();
      n_cmp++;
      if (seg_sel !== exp_sel || seg_out !== exp_out) begin
        n_bad++;
        $display("FAIL enable_resume sel=%b out=%h required sel=%b out=%h", seg_sel, seg_out, exp_sel, exp_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    logic [3:0] lsel;
    while ((cnt % 16) != 9 && guard < 32) begin
      step();
      guard++;
    end
    rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 7'h11;
    step();
    rst = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (seg_sel !== 4'h0 || seg_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid_edge sel=%b out=%h required sel=0000 out=00", seg_sel, seg_out);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      lsel = ((i % 4) == 0) ? 4'h0 : 4'(1 << (i / 4));
      n_cmp++;
      if (seg_sel !== lsel || seg_out !== ((lsel == 4'h0) ? 8'h00 : 8'h01) || seg_out !== exp_out) begin
        n_bad++;
        $display("FAIL reset_mid_scan cyc=%0d sel=%b out=%h required sel=%b out=%h", i, seg_sel, seg_out, lsel, exp_out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 7'($urandom);
      enable   = ($urandom_range(0, 15) != 0);
      wr3_en   = ($urandom_range(0, 3) == 0);
      wr3_addr = 2'($urandom_range(0, 3));
      wr3_data = 7'($urandom);
      step();
      n_cmp++;
      if (seg_sel !== exp_sel || seg_out !== exp_out || seg_sel3 !== exp_sel3 || seg_out3 !== exp_out3) begin
        n_bad++;
        $display("FAIL random cyc=%0d sel=%b out=%h required sel=%b out=%h ; sel3=%b out3=%h required sel3=%b out3=%h",
                 i, seg_sel, seg_out, exp_sel, exp_out, seg_sel3, seg_out3, exp_sel3, exp_out3);
      end
    end
    wr_en = 1'b0; wr3_en = 1'b0; enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    en3 = 1'b1; wr3_en = 1'b0; wr3_addr = '0; wr3_data = '0;
    cnt = 0; cnt3 = 0;
    test_reset();
    test_decode();
    test_blink();
    test_midslot();
    test_out_of_range();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
